// File: rtl/read_write_logic.sv
// read_write_logic: 8259 bus front end that samples the pins, runs the ICW sequence and decodes each committed write.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   CS, WR, RD, A0, D        processor bus pins (strobes active low)
//   ReadWriteinputData       byte of the last valid command
//   FlagFromRW               one-cycle command code (0..3 ICW1..4, 4..6 OCW1..3, 7 none)
//   read2controlRW           status read select (011 IMR, 001 IRR, 101 ISR, 000 none)
//   init_done                high while the init sequence is complete
module read_write_logic (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CS,
  input  logic       WR,
  input  logic       RD,
  input  logic       A0,
  input  logic [7:0] D,
  output logic [7:0] ReadWriteinputData,
  output logic [2:0] FlagFromRW,
  output logic [2:0] read2controlRW,
  output logic       init_done
);
  typedef enum logic [2:0] {IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;
  state_t state, nxt;
  logic s_cs, s_wr, s_rd, s_a0, wr_d;
  logic [7:0] s_d, cap_d;
  logic cap_a0, cap_cs, sngl, ic4, ris;
  logic commit, icw1, rdy;
  logic [2:0] code;
  always_comb begin
    commit = ~wr_d & s_wr & cap_cs;
    icw1 = ~cap_a0 & cap_d[4];
    rdy = state == READY;
    // A0=0 non-ICW1 bytes have D[4]=0, so D[3] alone separates OCW2 from OCW3
    code = !commit ? 3'd7 : icw1 ? 3'd0 : !cap_a0 ? (rdy ? (cap_d[3] ? 3'd6 : 3'd5) : 3'd7) :
           state == WAIT_ICW2 ? 3'd1 : state == WAIT_ICW3 ? 3'd2 : state == WAIT_ICW4 ? 3'd3 : rdy ? 3'd4 : 3'd7;
    nxt = code == 3'd0 ? WAIT_ICW2 :
          code == 3'd1 ? (!sngl ? WAIT_ICW3 : ic4 ? WAIT_ICW4 : READY) :
          code == 3'd2 ? (ic4 ? WAIT_ICW4 : READY) :
          code == 3'd3 ? READY : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cs <= 1'b1;
      s_wr <= 1'b1;
      s_rd <= 1'b1;
      s_a0 <= 1'b0;
      s_d <= 8'h00;
      wr_d <= 1'b1;
      cap_d <= 8'h00;
      cap_a0 <= 1'b0;
      cap_cs <= 1'b0;
      state <= IDLE;
      sngl <= 1'b0;
      ic4 <= 1'b0;
      ris <= 1'b0;
      FlagFromRW <= 3'd7;
      ReadWriteinputData <= 8'h00;
      read2controlRW <= 3'b000;
      init_done <= 1'b0;
    end else begin
      s_cs <= CS;
      s_wr <= WR;
      s_rd <= RD;
      s_a0 <= A0;
      s_d <= D;
      wr_d <= s_wr;
      // CS qualification follows every WR-low cycle so a strobe with CS high never commits
      cap_cs <= s_wr ? cap_cs : ~s_cs;
      cap_d <= (~s_cs & ~s_wr) ? s_d : cap_d;
      cap_a0 <= (~s_cs & ~s_wr) ? s_a0 : cap_a0;
      state <= nxt;
      FlagFromRW <= code;
      ReadWriteinputData <= code != 3'd7 ? cap_d : ReadWriteinputData;
      init_done <= nxt == READY;
      sngl <= code == 3'd0 ? cap_d[1] : sngl;
      ic4 <= code == 3'd0 ? cap_d[0] : ic4;
      ris <= (code == 3'd6 && cap_d[1]) ? cap_d[0] : ris;
      read2controlRW <= (~s_cs & ~s_rd & s_wr) ? (s_a0 ? 3'b011 : {ris, 2'b01}) : 3'b000;
    end
  end
endmodule
